// File: rtl/piso_pkg.sv
// Shared types for the PISO serializer: FSM state encoding and bit-counter width helper.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter must reach WIDTH (the parity slot) without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: counts bits already shifted out and flags the final bit of the frame.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        inc,
    input  logic [cnt_width(WIDTH)-1:0] term,
    output logic                        last
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] cnt;

    assign last = (cnt == term);

    // Saturates at the terminal count so a held inc can never wrap mid-frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !last) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with ready/valid loading and back-to-back framing.
// Optional even-parity bit appended to each frame when PISO_PARITY_EN is defined.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
`ifdef PISO_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif
    localparam logic [CW-1:0] TERM = CW'(SW - 1);

    state_t        state;
    logic [SW-1:0] shreg;
    logic [SW-1:0] frame_word;
    logic          last;
    logic          head;
    logic          load;
    logic          advance;
    logic          frame_end;

    // Parity rides in the shift register at the tail of the shift order, so it falls out last.
`ifdef PISO_PARITY_EN
    assign frame_word = MSB_FIRST ? {din, ^din} : {^din, din};
`else
    assign frame_word = din;
`endif

    assign head       = MSB_FIRST ? shreg[SW-1] : shreg[0];
    assign busy       = (state == SHIFT);
    assign din_ready  = en && ((state == IDLE) || last);
    assign load       = din_valid && din_ready;
    assign advance    = en && busy && !last;
    assign frame_end  = en && busy && last;

    assign sout       = busy & head;
    assign sout_valid = busy;
    assign sout_last  = busy & last;

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (load || frame_end),
        .inc   (advance),
        .term  (TERM),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
        end else if (load) begin
            shreg <= frame_word;
            state <= SHIFT;
        end else if (advance) begin
            shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
        end else if (frame_end) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: LSB-first and MSB-first instances driven in lockstep.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FRAME = 5;
`else
    localparam int FRAME = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       din_valid = 1'b0;
    logic [3:0] din = 4'h0;

    logic ready0, sout0, sv0, sl0, busy0;
    logic ready1, sout1, sv1, sl1, busy1;

    int total = 0;
    int bad = 0;
    int busy_cnt = 0;

    // Each entry: {expected bit, expected last flag}
    logic [1:0] q0[$];
    logic [1:0] q1[$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(ready0), .sout(sout0), .sout_valid(sv0), .sout_last(sl0), .busy(busy0)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(ready1), .sout(sout1), .sout_valid(sv1), .sout_last(sl1), .busy(busy1)
    );

    task automatic chk(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0b required=%0b", name, act, req);
        end
    endtask

    task automatic chk_n(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Expected sequences are written in emission order, first bit leftmost; bit 0 is the parity slot.
    task automatic push_exp(input logic [4:0] e0, input logic [4:0] e1);
        for (int i = 0; i < FRAME; i++) begin
            q0.push_back({e0[4-i], (i == FRAME - 1)});
            q1.push_back({e1[4-i], (i == FRAME - 1)});
        end
    endtask

    task automatic load_word(input logic [3:0] w, input logic [4:0] e0, input logic [4:0] e1);
        din = w;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        push_exp(e0, e1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk_n({name, " drain0"}, q0.size(), 0);
        chk_n({name, " drain1"}, q1.size(), 0);
    endtask

    task automatic mon(input string tag, input logic s, input logic sv, input logic sl,
                       input logic rdy, input logic bz, input logic have,
                       input logic [1:0] e, output logic pop_it);
        pop_it = 1'b0;
        if (sv) begin
            chk({tag, " busy"}, bz, 1'b1);
            if (!have) begin
                chk({tag, " extra bit"}, sv, 1'b0);
            end else begin
                chk({tag, " sout"}, s, e[1]);
                chk({tag, " sout_last"}, sl, e[0]);
                chk({tag, " din_ready"}, rdy, en & e[0]);
                pop_it = en;
            end
        end else begin
            chk({tag, " valid"}, sv, have);
            chk({tag, " idle sout"}, s, 1'b0);
            chk({tag, " idle last"}, sl, 1'b0);
            chk({tag, " idle busy"}, bz, 1'b0);
            chk({tag, " idle ready"}, rdy, en);
        end
    endtask

    always @(negedge clk) begin
        logic p0, p1;
        logic [1:0] e0, e1;
        e0 = (q0.size() != 0) ? q0[0] : 2'b00;
        e1 = (q1.size() != 0) ? q1[0] : 2'b00;
        mon("lsb", sout0, sv0, sl0, ready0, busy0, q0.size() != 0, e0, p0);
        mon("msb", sout1, sv1, sl1, ready1, busy1, q1.size() != 0, e1, p1);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (busy0) busy_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset sout_valid", sv0, 1'b0);
        chk("reset busy", busy0, 1'b0);
        chk("reset sout", sout1, 1'b0);
        rst = 1'b1;
        #1;
        chk("ready after reset", ready0, 1'b1);
        en = 1'b0;
        #1;
        chk("ready follows en low", ready1, 1'b0);
        en = 1'b1;
        @(posedge clk);
        #1;

        // Single word 1011: LSB-first 1,1,0,1 / MSB-first 1,0,1,1, parity 1
        busy_cnt = 0;
        load_word(4'hB, 5'b11011, 5'b10111);
        drain("single");
        chk("busy cleared after frame", busy0, 1'b0);
        chk_n("busy cycles", busy_cnt, FRAME);

        // Back-to-back A then 5 with din_valid held; din=5 is offered while A is still shifting
        din = 4'hA;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        push_exp(5'b01010, 5'b10100);
        push_exp(5'b10100, 5'b01010);
        din = 4'h5;
        repeat (FRAME) @(posedge clk);
        #1;
        din_valid = 1'b0;
        drain("back2back");

        // en dropped for 3 cycles while the 2nd bit of 1100 is on sout
        load_word(4'hC, 5'b00110, 5'b11000);
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        drain("en hold");

        // Reset mid-frame after the 2nd bit, then 0011 serializes cleanly
        load_word(4'hF, 5'b11110, 5'b11110);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk("midreset sout0", sout0, 1'b0);
        chk("midreset valid0", sv0, 1'b0);
        chk("midreset busy0", busy0, 1'b0);
        chk("midreset sout1", sout1, 1'b0);
        chk("midreset valid1", sv1, 1'b0);
        chk("midreset busy1", busy1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        load_word(4'h3, 5'b11000, 5'b00110);
        drain("after reset");

        // 0111: parity bit 1 closes the frame when parity is enabled
        busy_cnt = 0;
        load_word(4'h7, 5'b11101, 5'b01111);
        drain("parity word");
        chk_n("parity busy cycles", busy_cnt, FRAME);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
